// File: rtl/tow_pkg.sv
// -----------------------------------------------------------------------------
// tow_pkg -- shared definitions for the tug-of-war round referee.
//   ref_state_e : referee state encoding (IDLE/ARM/LIT/RESULT/DONE)
//   LFSR_SEED   : power-up / reset value of the 16-bit random source
//   LFSR_TAPS   : Galois tap mask for x^16+x^14+x^13+x^11+1 (right-shifting)
//   lfsr_next() : one step of that Galois LFSR
// -----------------------------------------------------------------------------
package tow_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        LIT    = 3'd2,
        RESULT = 3'd3,
        DONE   = 3'd4
    } ref_state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Right-shift Galois step: the bit falling out of bit 0 folds back
    // through the tap mask. A non-zero state never maps to zero.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        logic [15:0] nxt;
        nxt = {1'b0, cur[15:1]};
        if (cur[0]) begin
            nxt = nxt ^ LFSR_TAPS;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/tow_lfsr.sv
// -----------------------------------------------------------------------------
// tow_lfsr -- 16-bit Galois LFSR with enable and synchronous seed load.
// Ports:
//   clk    in   system clock, rising edge
//   load   in   synchronous load of LFSR_SEED (highest priority)
//   en     in   advance one step this cycle
//   lfsr_o out  current LFSR state
// -----------------------------------------------------------------------------
module tow_lfsr
    import tow_pkg::*;
(
    input  logic        clk,
    input  logic        load,
    input  logic        en,
    output logic [15:0] lfsr_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/round_referee.sv
// -----------------------------------------------------------------------------
// round_referee -- sequences one tug-of-war round at a time: random lights-off
// delay (ARM), lights on (LIT), then arbitration of the first push. Flags
// jump-the-light pushes and same-cycle ties, and freezes in DONE once the
// scorer reports victory (only rst leaves DONE).
//
// Optional feature: define FAKE_ROUND_EN to mark rounds armed while
// lfsr[15:14] == 2'b00 as fake. Without it, fake is constant 0.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous, active-high reset
//   pb_l      in   left button level (debounced, synchronized)
//   pb_r      in   right button level (debounced, synchronized)
//   victory   in   scorer victory level; forces DONE
//   winrnd    out  one-cycle pulse when a round resolves
//   right     out  right player pushed first (held)
//   leds_on   out  lights were on at the resolving push (held)
//   tie       out  both pushed in the same cycle (held)
//   fake      out  last resolved round was fake (held)
//   lights    out  round lights drive, high in LIT only
//   busy      out  high in ARM or LIT
//   dbg_state out  current referee state (ref_state_e encoding)
//
// Handshake: none; inputs are levels, winrnd is a single-cycle strobe that
// the scorer must accept unconditionally, with right/leds_on/tie/fake
// already valid in the same cycle and held until the next resolution.
// -----------------------------------------------------------------------------
module round_referee
    import tow_pkg::*;
#(
    parameter int DELAY_MIN_CYC   = 4,
    parameter int DELAY_RAND_W    = 2,
    parameter int LED_TIMEOUT_CYC = 16,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pb_l,
    input  logic       pb_r,
    input  logic       victory,
    output logic       winrnd,
    output logic       right,
    output logic       leds_on,
    output logic       tie,
    output logic       fake,
    output logic       lights,
    output logic       busy,
    output logic [2:0] dbg_state
);

    ref_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pb_l_q, pb_l_d;
    logic             pb_r_q, pb_r_d;
    logic             fake_rnd_q, fake_rnd_d;
    logic             winrnd_q, winrnd_d;
    logic             right_q, right_d;
    logic             leds_on_q, leds_on_d;
    logic             tie_q, tie_d;
    logic             fake_q, fake_d;
    logic             lights_q, lights_d;
    logic             busy_q, busy_d;

    logic [15:0]      lfsr;
    logic             lfsr_unused;
    logic             push_l, push_r, push_any;
    logic             fake_arm;
    logic [CNT_W-1:0] delay_load;

    // The random source keeps running in every state but DONE.
    tow_lfsr u_lfsr (
        .clk    (clk),
        .load   (rst),
        .en     (state_q != DONE),
        .lfsr_o (lfsr)
    );

    // Only a few LFSR bits are consumed here; the rest are reserved for
    // other random users of the same source.
    assign lfsr_unused = ^lfsr;

    // Rising edges only; pb_*_q resets to 1 so a button held through reset
    // does not count as a push.
    assign push_l   = pb_l & ~pb_l_q;
    assign push_r   = pb_r & ~pb_r_q;
    assign push_any = push_l | push_r;

    assign delay_load = CNT_W'(DELAY_MIN_CYC) + CNT_W'(lfsr[DELAY_RAND_W-1:0]);

`ifdef FAKE_ROUND_EN
    assign fake_arm = (lfsr[15:14] == 2'b00);
`else
    assign fake_arm = 1'b0;
`endif

    // State register (plus all other flops).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pb_l_q     <= 1'b1;
            pb_r_q     <= 1'b1;
            fake_rnd_q <= 1'b0;
            winrnd_q   <= 1'b0;
            right_q    <= 1'b0;
            leds_on_q  <= 1'b0;
            tie_q      <= 1'b0;
            fake_q     <= 1'b0;
            lights_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pb_l_q     <= pb_l_d;
            pb_r_q     <= pb_r_d;
            fake_rnd_q <= fake_rnd_d;
            winrnd_q   <= winrnd_d;
            right_q    <= right_d;
            leds_on_q  <= leds_on_d;
            tie_q      <= tie_d;
            fake_q     <= fake_d;
            lights_q   <= lights_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state logic, shared down-counter and per-round fake latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fake_rnd_d = fake_rnd_q;
        pb_l_d     = pb_l;
        pb_r_d     = pb_r;

        case (state_q)
            IDLE: begin
                if (!pb_l && !pb_r) begin
                    state_d    = ARM;
                    cnt_d      = delay_load;
                    fake_rnd_d = fake_arm;
                end
            end
            ARM: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (push_any) begin
                    state_d = RESULT;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = LIT;
                    cnt_d   = CNT_W'(LED_TIMEOUT_CYC);
                end
            end
            LIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (push_any) begin
                    state_d = RESULT;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                end
            end
            RESULT: begin
                state_d = IDLE;
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Victory beats every other transition, including a push this cycle.
        if (victory) begin
            state_d = DONE;
        end
    end

    // Output logic: every output is registered from the next state, so a
    // push seen in cycle N shows as winrnd (with its results) in cycle N+1.
    always_comb begin
        winrnd_d  = (state_d == RESULT);
        lights_d  = (state_d == LIT);
        busy_d    = (state_d == ARM) || (state_d == LIT);
        right_d   = right_q;
        leds_on_d = leds_on_q;
        tie_d     = tie_q;
        fake_d    = fake_q;

        if (state_d == RESULT) begin
            tie_d     = push_l & push_r;
            right_d   = push_r & ~push_l;
            leds_on_d = (state_q == LIT);
            fake_d    = fake_rnd_q;
        end
    end

    assign winrnd    = winrnd_q;
    assign right     = right_q;
    assign leds_on   = leds_on_q;
    assign tie       = tie_q;
    assign fake      = fake_q;
    assign lights    = lights_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_round_referee.sv
// -----------------------------------------------------------------------------
// tb_round_referee -- directed + randomized bench for round_referee.
// Reference model: an arithmetic copy of the LFSR sequence plus per-round
// rules (ARM length = 4 + lfsr[1:0], LIT window of 16 cycles, results from
// which buttons rose first). Works with or without FAKE_ROUND_EN.
// -----------------------------------------------------------------------------
module tb_round_referee;
    import tow_pkg::*;

    localparam int DMIN    = 4;
    localparam int LIT_CYC = 16;

    logic       clk;
    logic       rst;
    logic       pb_l;
    logic       pb_r;
    logic       victory;
    logic       winrnd;
    logic       right;
    logic       leds_on;
    logic       tie;
    logic       fake;
    logic       lights;
    logic       busy;
    logic [2:0] dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model state: LFSR value of the current cycle and whether DONE is held.
    logic [15:0] m_lfsr;
    bit          m_done;
    logic        exp_right, exp_leds, exp_tie, exp_fake;

    round_referee dut (
        .clk       (clk),
        .rst       (rst),
        .pb_l      (pb_l),
        .pb_r      (pb_r),
        .victory   (victory),
        .winrnd    (winrnd),
        .right     (right),
        .leds_on   (leds_on),
        .tie       (tie),
        .fake      (fake),
        .lights    (lights),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic logic [15:0] model_step(input logic [15:0] v);
        int x;
        x = int'(v);
        if (x % 2 == 1) x = (x / 2) ^ 32'h0000B400;
        else            x = x / 2;
        return x[15:0];
    endfunction

    // One clock: advance the model across the edge, then settle 1 unit later.
    task automatic step();
        @(posedge clk);
        if (rst)          m_lfsr = 16'hACE1;
        else if (!m_done) m_lfsr = model_step(m_lfsr);
        if (rst)          m_done = 0;
        else if (victory) m_done = 1;
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_held(input string tag);
        check({tag, "_right"}, 32'(right),   32'(exp_right));
        check({tag, "_leds"},  32'(leds_on), 32'(exp_leds));
        check({tag, "_tie"},   32'(tie),     32'(exp_tie));
        check({tag, "_fake"},  32'(fake),    32'(exp_fake));
    endtask

    task automatic check_reset_outputs();
        check("rst_winrnd", 32'(winrnd),    0);
        check("rst_right",  32'(right),     0);
        check("rst_leds",   32'(leds_on),   0);
        check("rst_tie",    32'(tie),       0);
        check("rst_fake",   32'(fake),      0);
        check("rst_lights", 32'(lights),    0);
        check("rst_busy",   32'(busy),      0);
        check("rst_state",  32'(dbg_state), 32'(IDLE));
        exp_right = 0; exp_leds = 0; exp_tie = 0; exp_fake = 0;
    endtask

    function automatic logic model_fake(input logic [15:0] v);
`ifdef FAKE_ROUND_EN
        return (v[15:14] == 2'b00);
`else
        return (v == 16'h0) & (v != 16'h0);
`endif
    endfunction

    // Precondition: current cycle is IDLE with both buttons released.
    // phase 0 = no push (timeout), 1 = push in ARM cycle 'at', 2 = push in
    // LIT cycle 'at' (clamped to the last cycle of that phase).
    // Leaves the bench in an IDLE cycle with both buttons released.
    task automatic play_round(input int phase, input int at, input logic pl, input logic pr);
        int   arm_len;
        int   when;
        int   hold;
        logic fk;
        bit   pushed;
        arm_len = DMIN + int'(m_lfsr[1:0]);
        fk      = model_fake(m_lfsr);
        pushed  = 0;
        step();
        when = (phase == 1 && at > arm_len) ? arm_len : at;
        for (int i = 1; i <= arm_len; i++) begin
            check("arm_busy",   32'(busy),   1);
            check("arm_lights", 32'(lights), 0);
            check("arm_winrnd", 32'(winrnd), 0);
            if (phase == 1 && i == when) begin
                pb_l = pl; pb_r = pr; pushed = 1;
            end
            step();
            if (pushed) break;
        end
        if (!pushed) begin
            when = (at > LIT_CYC) ? LIT_CYC : at;
            for (int i = 1; i <= LIT_CYC; i++) begin
                check("lit_busy",   32'(busy),   1);
                check("lit_lights", 32'(lights), 1);
                check("lit_winrnd", 32'(winrnd), 0);
                if (phase == 2 && i == when) begin
                    pb_l = pl; pb_r = pr; pushed = 1;
                end
                step();
                if (pushed) break;
            end
        end
        if (pushed) begin
            exp_right = pr & ~pl;
            exp_tie   = pl & pr;
            exp_leds  = (phase == 2);
            exp_fake  = fk;
            check("res_winrnd", 32'(winrnd), 1);
            check("res_busy",   32'(busy),   0);
            check("res_lights", 32'(lights), 0);
            check_held("res");
            step();
            check("post_winrnd", 32'(winrnd), 0);
            check("post_busy",   32'(busy),   0);
            hold = $urandom_range(0, 3);
            repeat (hold) begin
                step();
                check("hold_busy",   32'(busy),   0);
                check("hold_winrnd", 32'(winrnd), 0);
            end
            pb_l = 0; pb_r = 0;
        end else begin
            check("tmo_winrnd", 32'(winrnd), 0);
            check("tmo_busy",   32'(busy),   0);
            check("tmo_lights", 32'(lights), 0);
            check_held("tmo");
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int   arm_len;
        int   v;
        logic pl, pr;

        rst = 1; pb_l = 0; pb_r = 0; victory = 0;
        m_lfsr = 16'hACE1; m_done = 0;
        exp_right = 0; exp_leds = 0; exp_tie = 0; exp_fake = 0;
        step();
        step();
        check_reset_outputs();
        rst = 0;

        // Seed low bits 01: ARM of 5 cycles, pb_r edge 3 cycles into LIT.
        play_round(2, 4, 1'b0, 1'b1);
        // Jump-the-light by pb_l in the 2nd ARM cycle.
        play_round(1, 2, 1'b1, 1'b0);
        // Same-cycle tie in LIT.
        play_round(2, $urandom_range(1, LIT_CYC), 1'b1, 1'b1);
        // Timeout: nothing pushed, held results stay.
        play_round(0, 0, 1'b0, 1'b0);
        // Boundaries: push on the last ARM cycle and the last LIT cycle.
        play_round(1, 99, 1'b0, 1'b1);
        play_round(2, LIT_CYC, 1'b1, 1'b0);

        // Randomized rounds.
        for (int r = 0; r < 24; r++) begin
            v  = $urandom_range(1, 3);
            pl = v[0];
            pr = v[1];
            play_round($urandom_range(0, 2), $urandom_range(1, LIT_CYC), pl, pr);
        end

        // Reset in the middle of ARM: no winrnd, everything cleared.
        play_round(2, 2, 1'b0, 1'b1);
        step();
        step();
        check("mid_busy", 32'(busy), 1);
        rst = 1;
        step();
        check_reset_outputs();
        rst = 0;

        // Button held through reset does not arm until released.
        pb_r = 1; rst = 1;
        step();
        rst = 0;
        repeat (3) begin
            step();
            check("held_busy",   32'(busy),   0);
            check("held_winrnd", 32'(winrnd), 0);
        end
        pb_r = 0;
        play_round(2, 3, 1'b1, 1'b0);

        // Victory in LIT together with a pb_r edge: DONE, no winrnd.
        arm_len = DMIN + int'(m_lfsr[1:0]);
        repeat (arm_len + 3) step();
        check("vic_lights", 32'(lights), 1);
        victory = 1; pb_r = 1;
        step();
        check("vic_winrnd", 32'(winrnd),    0);
        check("vic_busy",   32'(busy),      0);
        check("vic_lights", 32'(lights),    0);
        check("vic_state",  32'(dbg_state), 32'(DONE));
        check_held("vic");
        victory = 0;
        for (int i = 0; i < 8; i++) begin
            pb_l = ~pb_l;
            if (i % 3 == 0) pb_r = ~pb_r;
            step();
            check("done_winrnd", 32'(winrnd),    0);
            check("done_busy",   32'(busy),      0);
            check("done_state",  32'(dbg_state), 32'(DONE));
            check_held("done");
        end
        pb_l = 0; pb_r = 0;
        rst = 1;
        step();
        check_reset_outputs();
        rst = 0;
        play_round(2, $urandom_range(1, LIT_CYC), 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/round_referee.md
Name: round_referee

Overview:
- Sequences each tug-of-war round and produces the `winrnd` / `right` / `leds_on` / `tie` / `fake` controls that drive the scorer.
- Per round: random pre-light delay, then lights on, then arbitration of the first push between the two players.
- Detects jump-the-light pushes and same-cycle ties; optionally inserts fake rounds.
- Freezes once the scorer reports victory.
- Sits between the debounced pushbutton front end and the scorer.

Parameters:
- DELAY_MIN_CYC, 4, minimum ARM (lights-off) duration in cycles.
- DELAY_RAND_W, 2, width of the random delay addend taken from the LFSR.
- LED_TIMEOUT_CYC, 16, cycles in LIT with no push before the round is voided.
- CNT_W, 8, width of the shared down-counter; must hold DELAY_MIN_CYC+2^DELAY_RAND_W-1 and LED_TIMEOUT_CYC.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- pb_l  in  1  left player button, debounced and synchronized upstream, level.
- pb_r  in  1  right player button, same conditioning.
- victory  in  1  scorer Victory level.
- winrnd  out  1  one-cycle pulse: round resolved.
- right  out  1  1 = right pushed first; held until next resolution.
- leds_on  out  1  lights were on at the resolving push; held.
- tie  out  1  both pushed in the same cycle; held.
- fake  out  1  current/last-resolved round is fake; held.
- lights  out  1  drive for the round lights (1 in LIT only).
- busy  out  1  high in ARM or LIT.

Behaviour:
- All outputs registered.
- Reset values:
  - state IDLE, counter 0, LFSR 16'hACE1.
  - `winrnd` 0, `right` 0, `leds_on` 0, `tie` 0, `fake` 0, `lights` 0, `busy` 0.
  - `pb_l_q` / `pb_r_q` = 1, so a button held through reset gives no edge.
- Edge detect:
  - `push_l = pb_l & ~pb_l_q`; `push_r` likewise.
  - `pb_*_q` updates every cycle.
  - Only rising edges count.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Advances every cycle except in DONE.
  - Never reaches 0.
- States: IDLE, ARM, LIT, RESULT, DONE.
- Priority in every state: `victory` = 1 → DONE next cycle. This overrides all other transitions except `rst`.
- IDLE:
  - When `pb_l` = 0 and `pb_r` = 0: load counter = DELAY_MIN_CYC + `lfsr[DELAY_RAND_W-1:0]`, latch the fake decision for the round, go to ARM.
  - Otherwise stay in IDLE.
- ARM:
  - Counter decrements each cycle; `lights` = 0.
  - Any push → RESULT with `leds_on` = 0 (jump-the-light).
  - Counter == 1 with no push → load LED_TIMEOUT_CYC, go to LIT.
- LIT:
  - `lights` = 1; counter decrements.
  - Any push → RESULT with `leds_on` = 1.
  - Counter == 1 with no push → IDLE; round voided, no `winrnd`, held outputs unchanged.
- Resolve, evaluated in the transition cycle:
  - `tie` = `push_l & push_r`.
  - `right` = `push_r & ~push_l`.
  - `fake` = latched round flag.
  - All loaded together.
- RESULT:
  - `winrnd` = 1 for exactly this one cycle, then IDLE.
  - IDLE re-arms only after both buttons are released.
- Latency: the push edge is seen in cycle N; `winrnd` is high in cycle N+1. `right` / `leds_on` / `tie` are already valid in N+1.
- DONE:
  - `winrnd` = 0, `lights` = 0, `busy` = 0.
  - Held outputs keep their last values.
  - Leaves only on `rst`; `victory` deasserting does not exit DONE.
- `rst` mid-round → IDLE at the next edge. No `winrnd` is emitted for a round interrupted by `rst`.

Optional Feature:
- Macro `FAKE_ROUND_EN`.
- Defined:
  - The round is fake when `lfsr[15:14]` == 2'b00 at IDLE→ARM.
  - The flag is latched for the round.
  - `fake` is loaded at resolve.
  - `lights` is still driven in LIT, so the display shows the fake pattern downstream.
- Undefined: the fake flag is constant 0, `fake` output tied 0, no LFSR bits consumed for it.

Decomposition:
- Package `tow_pkg`:
  - referee state enum (IDLE/ARM/LIT/RESULT/DONE).
  - LFSR seed 16'hACE1 and tap mask 16'hB400.
- One sub-module, `tow_lfsr` (16-bit Galois LFSR with enable and synchronous seed load), shared with future random-delay users.

Test Plan:
- Reset, LFSR low bits = 2'b01: `pb_r` edge 3 cycles after entering LIT → `winrnd` pulse 1 cycle later with `right`=1, `leds_on`=1, `tie`=0; ARM lasted exactly 5 cycles.
- `pb_l` edge in the 2nd ARM cycle → `winrnd` next cycle, `right`=0, `leds_on`=0, `lights` never asserted that round.
- `pb_l` and `pb_r` rising in the same LIT cycle → `winrnd`=1, `tie`=1, `right`=0, `leds_on`=1.
- No push in LIT → after 16 cycles back in IDLE, no `winrnd`, prior `right`/`leds_on`/`tie` unchanged; `pb_r` held high blocks IDLE→ARM until released.
- `victory`=1 during LIT with a simultaneous `pb_r` edge → DONE, no `winrnd`; later pushes ignored; `rst` → all outputs 0, state IDLE.
- `FAKE_ROUND_EN` defined, LFSR forced so `[15:14]`=00 at arm → `pb_l` push in LIT gives `fake`=1 with `winrnd`. Same stimulus with the macro undefined gives `fake`=0.
